// File: rtl/dsp_pkg.sv
// dsp_pkg: opmode bit positions, X/Z mux codes and string parameter values for the DSP48A1 slice.
package dsp_pkg;
  localparam int OP_PRE_EN = 4;
  localparam int OP_CIN = 5;
  localparam int OP_PRE_SUB = 6;
  localparam int OP_POST_SUB = 7;
  localparam logic [1:0] X_ZERO = 2'd0, X_M = 2'd1, X_P = 2'd2, X_DAB = 2'd3;
  localparam logic [1:0] Z_ZERO = 2'd0, Z_PCIN = 2'd1, Z_P = 2'd2, Z_C = 2'd3;
  localparam int STR_W = 56;
  localparam logic [STR_W-1:0] CARRYINSEL_OPMODE5 = STR_W'("OPMODE5");
  localparam logic [STR_W-1:0] CARRYINSEL_CARRYIN = STR_W'("CARRYIN");
  localparam logic [STR_W-1:0] B_INPUT_DIRECT = STR_W'("DIRECT");
  localparam logic [STR_W-1:0] B_INPUT_CASCADE = STR_W'("CASCADE");
endpackage

// File: rtl/dsp_reg_mux.sv
// dsp_reg_mux: pipeline stage with sync clear, clock enable and a bypass when REG=0.
module dsp_reg_mux
  import dsp_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter bit REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_d, r_q;
  always_comb r_d = rst ? '0 : ce ? d : r_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_q <= '0;
    else r_q <= r_d;
  assign q = REG ? r_q : d;
endmodule

// File: rtl/dsp48a1_slice.sv
// dsp48a1_slice: pre-adder, 18x18 multiplier and 48-bit post-adder/accumulator with bypassable stages.
// Define DSP_BCIN_CASCADE_EN to let B_INPUT="CASCADE" select BCIN; otherwise B always comes from the B port.
module dsp48a1_slice
  import dsp_pkg::*;
#(
  parameter bit A0REG = 1'b0,
  parameter bit A1REG = 1'b1,
  parameter bit B0REG = 1'b0,
  parameter bit B1REG = 1'b1,
  parameter bit CREG = 1'b1,
  parameter bit DREG = 1'b1,
  parameter bit MREG = 1'b1,
  parameter bit PREG = 1'b1,
  parameter bit CARRYINREG = 1'b1,
  parameter bit CARRYOUTREG = 1'b1,
  parameter bit OPMODEREG = 1'b1,
  parameter logic [STR_W-1:0] CARRYINSEL = CARRYINSEL_OPMODE5,
  parameter logic [STR_W-1:0] B_INPUT = B_INPUT_DIRECT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [17:0] A,
  input  logic [17:0] B,
  input  logic [17:0] D,
  input  logic [47:0] C,
  input  logic        carryin,
  input  logic [7:0]  opmode,
  input  logic [17:0] BCIN,
  input  logic [47:0] PCIN,
  input  logic        RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE,
  input  logic        CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE,
  output logic [17:0] BCOUT,
  output logic [47:0] PCOUT,
  output logic [47:0] P,
  output logic [35:0] M,
  output logic        CARRYOUT,
  output logic        CARRYOUTF
);
  logic [17:0] b_src, a0, a1, b0, b1, dr, pre;
  logic [47:0] cr, pr, x, z;
  logic [35:0] mr;
  logic [7:0]  op;
  logic        cin_src, cin, co;
  logic [48:0] sum;
`ifdef DSP_BCIN_CASCADE_EN
  assign b_src = (B_INPUT == B_INPUT_CASCADE) ? BCIN : B;
  logic unused_ok;
  assign unused_ok = ^{carryin, CARRYINSEL};
`else
  assign b_src = B;
  logic unused_ok;
  assign unused_ok = ^{BCIN, B_INPUT, carryin, CARRYINSEL};
`endif
  assign cin_src = (CARRYINSEL == CARRYINSEL_CARRYIN) ? carryin : opmode[OP_CIN];
  dsp_reg_mux #(.WIDTH(18), .REG(A0REG)) u_a0 (.clk, .rst_n, .rst(RSTA), .ce(CEA), .d(A), .q(a0));
  dsp_reg_mux #(.WIDTH(18), .REG(A1REG)) u_a1 (.clk, .rst_n, .rst(RSTA), .ce(CEA), .d(a0), .q(a1));
  dsp_reg_mux #(.WIDTH(18), .REG(B0REG)) u_b0 (.clk, .rst_n, .rst(RSTB), .ce(CEB), .d(b_src), .q(b0));
  dsp_reg_mux #(.WIDTH(18), .REG(B1REG)) u_b1 (.clk, .rst_n, .rst(RSTB), .ce(CEB), .d(pre), .q(b1));
  dsp_reg_mux #(.WIDTH(18), .REG(DREG)) u_d (.clk, .rst_n, .rst(RSTD), .ce(CED), .d(D), .q(dr));
  dsp_reg_mux #(.WIDTH(48), .REG(CREG)) u_c (.clk, .rst_n, .rst(RSTC), .ce(CEC), .d(C), .q(cr));
  dsp_reg_mux #(.WIDTH(8), .REG(OPMODEREG)) u_op (.clk, .rst_n, .rst(RSTOPMODE), .ce(CEOPMODE), .d(opmode), .q(op));
  dsp_reg_mux #(.WIDTH(36), .REG(MREG)) u_m (.clk, .rst_n, .rst(RSTM), .ce(CEM), .d(b1 * a1), .q(mr));
  dsp_reg_mux #(.WIDTH(1), .REG(CARRYINREG)) u_cin (.clk, .rst_n, .rst(RSTCARRYIN), .ce(CECARRYIN), .d(cin_src), .q(cin));
  dsp_reg_mux #(.WIDTH(48), .REG(PREG)) u_p (.clk, .rst_n, .rst(RSTP), .ce(CEP), .d(sum[47:0]), .q(pr));
  dsp_reg_mux #(.WIDTH(1), .REG(CARRYOUTREG)) u_co (.clk, .rst_n, .rst(RSTP), .ce(CEP), .d(sum[48]), .q(co));
  always_comb begin
    pre = !op[OP_PRE_EN] ? b0 : op[OP_PRE_SUB] ? dr - b0 : dr + b0;
    x = (op[1:0] == X_ZERO) ? '0 : (op[1:0] == X_M) ? {12'd0, mr} : (op[1:0] == X_P) ? pr : {dr[11:0], a1, b1};
    z = (op[3:2] == Z_ZERO) ? '0 : (op[3:2] == Z_PCIN) ? PCIN : (op[3:2] == Z_P) ? pr : cr;
    sum = op[OP_POST_SUB] ? {1'b0, z} - ({1'b0, x} + 49'(cin)) : {1'b0, z} + {1'b0, x} + 49'(cin);
  end
  assign BCOUT = b1;
  assign M = mr;
  assign P = pr;
  assign PCOUT = pr;
  assign CARRYOUT = co;
  assign CARRYOUTF = co;
endmodule

// File: tb/tb_dsp48a1_slice.sv
// tb_dsp48a1_slice: directed vector table plus hand-written reset, accumulate and hold sequences.
module tb_dsp48a1_slice;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [17:0] A = '0, B = '0, D = '0, BCIN = '0;
  logic [47:0] C = '0, PCIN = '0;
  logic        carryin = 1'b0;
  logic [7:0]  opmode = '0;
  logic RSTA = 0, RSTB = 0, RSTC = 0, RSTD = 0, RSTM = 0, RSTP = 0, RSTCARRYIN = 0, RSTOPMODE = 0;
  logic CEA = 1, CEB = 1, CEC = 1, CED = 1, CEM = 1, CEP = 1, CECARRYIN = 1, CEOPMODE = 1;
  logic [17:0] BCOUT;
  logic [47:0] PCOUT, P;
  logic [35:0] M;
  logic        CARRYOUT, CARRYOUTF;
  int checks = 0, failures = 0;

  dsp48a1_slice dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .D(D), .C(C), .carryin(carryin), .opmode(opmode),
    .BCIN(BCIN), .PCIN(PCIN),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
    .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .BCOUT(BCOUT), .PCOUT(PCOUT), .P(P), .M(M), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [17:0] a, b, d;
    logic [47:0] c, pcin;
    int          ncyc;
    logic [17:0] e_bc;
    logic [35:0] e_m;
    logic [47:0] e_p;
    logic        e_co;
  } vec_t;
  vec_t vt[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [17:0] bc, input logic [35:0] m, input logic [47:0] p, input logic co);
    chk({tag, ".BCOUT"}, 64'(BCOUT), 64'(bc));
    chk({tag, ".M"}, 64'(M), 64'(m));
    chk({tag, ".P"}, 64'(P), 64'(p));
    chk({tag, ".PCOUT"}, 64'(PCOUT), 64'(p));
    chk({tag, ".CARRYOUT"}, 64'(CARRYOUT), 64'(co));
    chk({tag, ".CARRYOUTF"}, 64'(CARRYOUTF), 64'(co));
  endtask

  task automatic set_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = {8{v}};
  endtask

  task automatic set_ce(input logic [7:0] v);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = v;
  endtask

  initial begin
    vt[0] = '{8'hDD, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 4, 18'd15, 36'd300, 48'd50, 1'b0};
    vt[1] = '{8'h10, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 3, 18'd35, 36'd700, 48'd0, 1'b0};
    vt[2] = '{8'h0A, 18'd20, 18'd10, 18'd25, 48'd350, 48'd0, 3, 18'd10, 36'd200, 48'd0, 1'b0};
    vt[3] = '{8'hA7, 18'd5, 18'd6, 18'd25, 48'd350, 48'd3000, 3, 18'd6, 36'd30, 48'hFE6FFFEC0BB1, 1'b1};
    vt[4] = '{8'h0D, 18'd1, 18'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 48'd0, 4, 18'd1, 36'd1, 48'd0, 1'b1};
    vt[5] = '{8'h50, 18'd2, 18'd5, 18'd3, 48'd0, 48'd0, 4, 18'h3FFFE, 36'h7FFFC, 48'd0, 1'b0};
    BCIN = 18'h2AAAA;
    #12;
    chk_all("in_reset", '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    set_rst(1'b1);
    for (int i = 0; i < 3; i++) begin
      A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
      C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
      opmode = 8'($urandom); carryin = 1'($urandom);
      set_ce(8'($urandom));
      @(negedge clk);
    end
    chk_all("sync_clear", '0, '0, '0, 1'b0);
    set_rst(1'b0);
    set_ce(8'hFF);
    carryin = 1'b0;
    for (int i = 0; i < 6; i++) begin
      opmode = vt[i].op; A = vt[i].a; B = vt[i].b; D = vt[i].d; C = vt[i].c; PCIN = vt[i].pcin;
      repeat (vt[i].ncyc) @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vt[i].e_bc, vt[i].e_m, vt[i].e_p, vt[i].e_co);
    end
    opmode = 8'h00; A = 18'd2; B = 18'd3; D = 18'd0; C = '0; PCIN = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk_all("acc_setup", 18'd3, 36'd6, 48'd0, 1'b0);
    opmode = 8'h09;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("acc.P", 64'(P), 64'd18);
    chk("acc.CARRYOUT", 64'(CARRYOUT), 64'd0);
    CEP = 1'b0; opmode = 8'h0D; C = 48'hFFFF_FFFF_FFFF; PCIN = 48'd77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold.P", 64'(P), 64'd18);
    chk("hold.CARRYOUT", 64'(CARRYOUT), 64'd0);
    RSTP = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rstp.P", 64'(P), 64'd0);
    chk("rstp.M", 64'(M), 64'd6);
    RSTP = 1'b0; CEP = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("wrap.P", 64'(P), 64'd5);
    chk("wrap.CARRYOUT", 64'(CARRYOUT), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", '0, '0, '0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
